// File: rtl/sram_seq_pkg.sv
// Shared types and constants for the SRAM access sequencer.
package sram_seq_pkg;

  localparam int SEQ_ADDR_W = 20;
  localparam int SEQ_DATA_W = 16;

  // {CE, UB, LB, OE, WE}, all active low, so all-ones is "bus idle"
  localparam logic [4:0] STROBE_OFF = 5'b11111;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    RECOVER,
    RESP
  } state_t;

  typedef struct packed {
    logic                  we;
    logic [SEQ_ADDR_W-1:0] addr;
    logic [SEQ_DATA_W-1:0] wdata;
    logic [1:0]            be;
  } request_t;

  // A request with no lanes selected is taken to mean the whole word
  function automatic logic [1:0] effective_be(input logic [1:0] be);
    return (be == 2'b00) ? 2'b11 : be;
  endfunction

  // Expands {upper,lower} lane selects into a 16-bit data mask
  function automatic logic [SEQ_DATA_W-1:0] lane_mask(input logic [1:0] be);
    return {{8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/sram_data_pad.sv
// Tristate driver for the SRAM data bus plus the read capture register.
module sram_data_pad #(
  parameter int DATA_W = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              drive_en,
  input  logic [DATA_W-1:0] wdata,
  input  logic              capture_en,
  output logic [DATA_W-1:0] rdata,
  inout  wire  [DATA_W-1:0] Data
);

  assign Data = drive_en ? wdata : {DATA_W{1'bz}};

  // Grab the bus on the final wait-state edge of a read
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      rdata <= '0;
    end else if (capture_en) begin
      rdata <= Data;
    end
  end

endmodule

// File: rtl/sram_access_sequencer.sv
// Turns single valid/ready memory requests into SRAM strobe cycles:
// SETUP (address + CE, bus turned around), ACCESS (OE or WE held for
// WAIT_STATES+1 cycles), RECOVER (hold), RESP (one-cycle completion pulse).
// Optional feature macro: SRAM_SEQ_BYTELANE_EN -- when defined, UB/LB follow
// the latched byte enables and unselected read lanes are zeroed; otherwise
// req_be is ignored and UB/LB track CE.
module sram_access_sequencer
  import sram_seq_pkg::*;
#(
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 16,
  parameter int WAIT_STATES = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [1:0]        req_be,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              CE,
  output logic              UB,
  output logic              LB,
  output logic              OE,
  output logic              WE,
  output logic [ADDR_W-1:0] ADDR,
  inout  wire  [DATA_W-1:0] Data
);

  // The request struct is sized from package constants, so the widths are fixed
  if (ADDR_W != SEQ_ADDR_W || DATA_W != SEQ_DATA_W) begin : g_width_check
    $error("sram_access_sequencer: ADDR_W must be 20 and DATA_W must be 16");
  end
  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_wait_check
    $error("sram_access_sequencer: WAIT_STATES must be 0..15");
  end

  state_t            state;
  state_t            next_state;
  request_t          req_q;
  logic [3:0]        wait_cnt;
  logic [DATA_W-1:0] cap_data;
  logic [DATA_W-1:0] read_word;
  logic [1:0]        be_in;
  logic [1:0]        lane_n;
  logic [4:0]        strobes;
  logic              ce_n;
  logic              oe_n;
  logic              we_n;
  logic              drive_en;
  logic              capture_en;
  logic              accept;

  assign req_ready = Reset && (state == IDLE);
  assign accept    = req_valid && req_ready;

`ifdef SRAM_SEQ_BYTELANE_EN
  assign be_in     = effective_be(req_be);
  assign read_word = cap_data & lane_mask(req_q.be);
`else
  logic unused_be;
  assign unused_be = ^{req_be, req_q.be};
  assign be_in     = 2'b11;
  assign read_word = cap_data;
`endif

  // State register
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: fixed walk through the phases, ACCESS stretched by the counter
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = SETUP;
      SETUP:   next_state = ACCESS;
      ACCESS:  if (wait_cnt == 4'd0) next_state = RECOVER;
      RECOVER: next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Request latch, wait-state counter and response data register
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      req_q     <= '0;
      wait_cnt  <= '0;
      rsp_rdata <= '0;
    end else begin
      if (accept) begin
        req_q.we    <= req_we;
        req_q.addr  <= req_addr;
        req_q.wdata <= req_wdata;
        req_q.be    <= be_in;
      end
      if (state == SETUP) begin
        wait_cnt <= 4'(WAIT_STATES);
      end else if (state == ACCESS && wait_cnt != 4'd0) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (state == RECOVER) begin
        rsp_rdata <= req_q.we ? '0 : read_word;
      end
    end
  end

  // Output decode: strobes, bus drive/capture enables and the response pulse
  always_comb begin
    ce_n       = 1'b1;
    oe_n       = 1'b1;
    we_n       = 1'b1;
    drive_en   = 1'b0;
    capture_en = 1'b0;
    rsp_valid  = 1'b0;
    lane_n     = 2'b00;
    strobes    = STROBE_OFF;
    case (state)
      SETUP: ce_n = 1'b0;
      ACCESS: begin
        ce_n = 1'b0;
        if (req_q.we) begin
          we_n     = 1'b0;
          drive_en = 1'b1;
        end else begin
          oe_n       = 1'b0;
          capture_en = (wait_cnt == 4'd0);
        end
      end
      RECOVER: begin
        ce_n     = 1'b0;
        drive_en = req_q.we;
      end
      RESP:    rsp_valid = 1'b1;
      default: ;
    endcase
`ifdef SRAM_SEQ_BYTELANE_EN
    lane_n = ~req_q.be;
`endif
    if (!ce_n) begin
      strobes = {1'b0, lane_n, oe_n, we_n};
    end
  end

  assign {CE, UB, LB, OE, WE} = strobes;
  assign ADDR = req_q.addr;

  sram_data_pad #(
    .DATA_W(DATA_W)
  ) u_pad (
    .Clk       (Clk),
    .Reset     (Reset),
    .drive_en  (drive_en),
    .wdata     (req_q.wdata),
    .capture_en(capture_en),
    .rdata     (cap_data),
    .Data      (Data)
  );

endmodule

// File: tb/tb_sram_access_sequencer.sv
// Self-checking bench for sram_access_sequencer with a small SRAM model.
// Responses are checked by a scoreboard monitor; strobe timing is checked
// per transaction by the stimulus tasks.
module tb_sram_access_sequencer;

  localparam int WS = 2;

  typedef struct {
    logic [15:0] rdata;
    int          cyc;
  } exp_t;

  logic        Clk;
  logic        Reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [19:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_be;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        CE, UB, LB, OE, WE;
  logic [19:0] ADDR;
  wire  [15:0] Data;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  logic [15:0] mem [0:255];

  sram_access_sequencer #(
    .ADDR_W     (20),
    .DATA_W     (16),
    .WAIT_STATES(WS)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_be   (req_be),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .CE       (CE),
    .UB       (UB),
    .LB       (LB),
    .OE       (OE),
    .WE       (WE),
    .ADDR     (ADDR),
    .Data     (Data)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  // SRAM model: drives the bus on reads, stores selected byte lanes on writes
  assign Data = (!CE && !OE && WE) ? mem[ADDR[7:0]] : 16'hzzzz;

  always @(posedge Clk) begin
    if (!CE && !WE) begin
      if (!UB) mem[ADDR[7:0]][15:8] <= Data[15:8];
      if (!LB) mem[ADDR[7:0]][7:0]  <= Data[7:0];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every response pulse must match the oldest expectation
  always @(negedge Clk) begin
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        checkOutput("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("rsp_rdata", {16'd0, rsp_rdata}, {16'd0, mon_e.rdata});
        checkOutput("rsp_cycle", cyc, mon_e.cyc);
      end
    end
  end

  task automatic waitReady();
    int n = 0;
    @(negedge Clk);
    while (!req_ready && n < 50) begin
      @(negedge Clk);
      n++;
    end
    checkOutput("req_ready_wait", {31'd0, req_ready}, 32'd1);
  endtask

  // One complete transaction with strobe-level timing checks
  task automatic applyStimulus(input logic we, input logic [19:0] addr, input logic [15:0] wdata,
                               input logic [1:0] be, input logic [15:0] exp_rdata);
    exp_t e;
    logic [1:0] exp_lanes;
    int acc, we_low, oe_low, drv, addr_err, lane_err;
    logic done;
`ifdef SRAM_SEQ_BYTELANE_EN
    exp_lanes = (be == 2'b00) ? 2'b00 : ~be;
`else
    exp_lanes = 2'b00;
`endif
    we_low = 0; oe_low = 0; drv = 0; addr_err = 0; lane_err = 0; done = 1'b0;
    waitReady();
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    acc = cyc + 1;
    e.rdata = exp_rdata;
    e.cyc   = acc + WS + 3;
    exp_q.push_back(e);
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      if (i == 0) req_valid = 1'b0;
      if (!WE) we_low++;
      if (!OE) oe_low++;
      if (we && Data === wdata) drv++;
      if (!CE) begin
        if (ADDR !== addr) addr_err++;
        if ({UB, LB} !== exp_lanes) lane_err++;
      end else if ({UB, LB} !== 2'b11) begin
        lane_err++;
      end
      if (rsp_valid) begin
        done = 1'b1;
        break;
      end
    end
    checkOutput("txn_done", {31'd0, done}, 32'd1);
    checkOutput("we_low_cycles", we_low, we ? WS + 1 : 0);
    checkOutput("oe_low_cycles", oe_low, we ? 0 : WS + 1);
    if (we) checkOutput("data_drive_cycles", drv, WS + 2);
    checkOutput("addr_errors", addr_err, 0);
    checkOutput("lane_errors", lane_err, 0);
  endtask

  task automatic drainScoreboard();
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge Clk);
      n++;
    end
    checkOutput("scoreboard_drained", exp_q.size(), 0);
  endtask

  initial begin
    int a_acc, ready_cyc;
    logic seen;
    exp_t e;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    Reset = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_addr = '0; req_wdata = '0; req_be = 2'b11;

    // Test 1: reset state
    repeat (3) @(negedge Clk);
    checkOutput("rst_strobes", {27'd0, CE, UB, LB, OE, WE}, 32'h1F);
    checkOutput("rst_ready", {31'd0, req_ready}, 32'd0);
    checkOutput("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("rst_rsp_rdata", {16'd0, rsp_rdata}, 32'd0);
    checkOutput("rst_addr", {12'd0, ADDR}, 32'd0);
    Reset = 1'b1;
    @(negedge Clk);
    checkOutput("ready_after_reset", {31'd0, req_ready}, 32'd1);

    // Tests 2-3: full-word write then read back, and response hold
    applyStimulus(1'b1, 20'h03000, 16'hBEEF, 2'b11, 16'h0000);
    applyStimulus(1'b0, 20'h03000, 16'h0000, 2'b11, 16'hBEEF);
    @(negedge Clk);
    checkOutput("rsp_pulse_single", {31'd0, rsp_valid}, 32'd0);
    checkOutput("rsp_rdata_hold", {16'd0, rsp_rdata}, 32'hBEEF);

    // Test 4: byte lanes, be==00 as full word, top-of-range address
    applyStimulus(1'b1, 20'h03001, 16'hA5C3, 2'b01, 16'h0000);
`ifdef SRAM_SEQ_BYTELANE_EN
    applyStimulus(1'b0, 20'h03001, 16'h0000, 2'b00, 16'h00C3);
`else
    applyStimulus(1'b0, 20'h03001, 16'h0000, 2'b00, 16'hA5C3);
`endif
    applyStimulus(1'b1, 20'hFFFFF, 16'h3456, 2'b11, 16'h0000);
    applyStimulus(1'b1, 20'hFFFFF, 16'h12AB, 2'b10, 16'h0000);
`ifdef SRAM_SEQ_BYTELANE_EN
    applyStimulus(1'b0, 20'hFFFFF, 16'h0000, 2'b11, 16'h1256);
    applyStimulus(1'b0, 20'hFFFFF, 16'h0000, 2'b10, 16'h1200);
`else
    applyStimulus(1'b0, 20'hFFFFF, 16'h0000, 2'b11, 16'h12AB);
    applyStimulus(1'b0, 20'hFFFFF, 16'h0000, 2'b10, 16'h12AB);
`endif

    // Test 5: request held while busy is taken only after RESP
    waitReady();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 20'h03000; req_be = 2'b11;
    a_acc = cyc + 1;
    e.rdata = 16'hBEEF; e.cyc = a_acc + WS + 3;
    exp_q.push_back(e);
    @(posedge Clk);
    #1;
    req_we = 1'b1; req_addr = 20'h00010; req_wdata = 16'h5A5A;
    e.rdata = 16'h0000; e.cyc = a_acc + WS + 5 + WS + 3;
    exp_q.push_back(e);
    seen = 1'b0; ready_cyc = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge Clk);
      if (req_ready) begin
        seen = 1'b1;
        ready_cyc = cyc;
      end
    end
    checkOutput("busy_second_accept", ready_cyc, a_acc + WS + 4);
    @(posedge Clk);
    #1 req_valid = 1'b0;
    drainScoreboard();

    // Test 6: reset during the ACCESS phase of a write aborts cleanly
    waitReady();
    req_valid = 1'b1; req_we = 1'b1; req_addr = 20'h00020; req_wdata = 16'h7777; req_be = 2'b11;
    @(negedge Clk);
    req_valid = 1'b0;
    @(negedge Clk);
    checkOutput("abort_we_before", {31'd0, WE}, 32'd0);
    Reset = 1'b0;
    #1;
    checkOutput("abort_we", {31'd0, WE}, 32'd1);
    checkOutput("abort_ce", {31'd0, CE}, 32'd1);
    checkOutput("abort_data_released", {31'd0, (Data === 16'h7777)}, 32'd0);
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    checkOutput("abort_ready", {31'd0, req_ready}, 32'd1);
    applyStimulus(1'b0, 20'h03000, 16'h0000, 2'b11, 16'hBEEF);
    applyStimulus(1'b0, 20'h00010, 16'h0000, 2'b11, 16'h5A5A);
    drainScoreboard();

    repeat (3) @(negedge Clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
